// File: rtl/ahb_lsu_master.sv
// ahb_lsu_master: single-beat AHB-Lite master for ARM load/store accesses.
// Replicates store data across byte lanes, and extracts and sign- or zero-extends
// load data for register writeback.
// Optional feature macro: LSU_UNALIGNED_ROTATE_EN. When defined, misaligned word
// accesses are issued word-aligned and load data is rotated (ARMv4 behaviour).
// When undefined, misaligned word accesses are rejected.
module ahb_lsu_master (
    input  logic        clk,
    input  logic        rst_n,
    // request from decode/execute
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd_id,
    // response to writeback
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [4:0]  rsp_rd_id,
    // AHB-Lite master
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransNonseq = 2'b10;

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  rd_id_q, rd_id_d;

    logic [31:0] haddr_q, haddr_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [31:0] hwdata_q, hwdata_d;

    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [4:0]  rsp_rd_id_q, rsp_rd_id_d;

    logic        req_illegal;

    // Store data is right-aligned; copy it onto every lane the slave may sample.
    function automatic logic [31:0] store_replicate(input logic [31:0] data,
                                                    input logic [1:0]  size);
        logic [31:0] r;
        case (size)
            2'b00:   r = {4{data[7:0]}};
            2'b01:   r = {2{data[15:0]}};
            default: r = data;
        endcase
        return r;
    endfunction

    // Pick the addressed lane out of the read bus and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] data,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lane,
                                                 input logic        sext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = data[7:0];
            2'd1:    b = data[15:8];
            2'd2:    b = data[23:16];
            default: b = data[31:24];
        endcase
        h = lane[1] ? data[31:16] : data[15:0];
        case (size)
            2'b00:   r = {{24{sext & b[7]}}, b};
            2'b01:   r = {{16{sext & h[15]}}, h};
            default: begin
`ifdef LSU_UNALIGNED_ROTATE_EN
                // Rotate right by 8 * addr[1:0].
                case (lane)
                    2'd0:    r = data;
                    2'd1:    r = {data[7:0], data[31:8]};
                    2'd2:    r = {data[15:0], data[31:16]};
                    default: r = {data[23:0], data[31:24]};
                endcase
`else
                r = data;
`endif
            end
        endcase
        return r;
    endfunction

    // Accesses that are rejected in IDLE without touching the bus.
    always_comb begin
`ifdef LSU_UNALIGNED_ROTATE_EN
        req_illegal = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]);
`else
        req_illegal = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`endif
    end

    // FSM next state together with the registered bus and response values.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        size_d      = size_q;
        sext_d      = sext_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        rd_id_d     = rd_id_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hwdata_d    = hwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_rd_id_d = rsp_rd_id_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    write_d = req_write;
                    size_d  = req_size;
                    sext_d  = req_signed;
                    lane_d  = req_addr[1:0];
                    wdata_d = req_wdata;
                    rd_id_d = req_rd_id;
                    if (req_illegal) begin
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0;
                        rsp_rd_id_d = req_rd_id;
                    end else begin
                        state_d  = StAddr;
                        htrans_d = HtransNonseq;
                        // Words go out word-aligned; only reachable misaligned with rotation.
                        haddr_d  = (req_size == 2'b10) ? {req_addr[31:2], 2'b00} : req_addr;
                        hwrite_d = req_write;
                        hsize_d  = {1'b0, req_size};
                    end
                end
            end
            StAddr: begin
                if (HREADY) begin
                    state_d  = StData;
                    htrans_d = HtransIdle;
                    hwdata_d = store_replicate(wdata_q, size_q);
                end
            end
            StData: begin
                // First cycle of a two-cycle ERROR has HREADY low and is simply waited out.
                if (HREADY) begin
                    state_d     = StResp;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = HRESP;
                    rsp_rdata_d = (HRESP || write_q) ? 32'h0
                                : load_extract(HRDATA, size_q, lane_q, sext_q);
                    rsp_rd_id_d = rd_id_q;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            write_q     <= 1'b0;
            size_q      <= 2'b00;
            sext_q      <= 1'b0;
            lane_q      <= 2'b00;
            wdata_q     <= 32'h0;
            rd_id_q     <= 5'd0;
            haddr_q     <= 32'h0;
            htrans_q    <= HtransIdle;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'b000;
            hwdata_q    <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_rd_id_q <= 5'd0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            rd_id_q     <= rd_id_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_rd_id_q <= rsp_rd_id_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_rd_id = rsp_rd_id_q;
    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HBURST    = 3'b000;
    assign HWDATA    = hwdata_q;

endmodule

// File: doc/ahb_lsu_master.md
# ahb_lsu_master

Load/store execution unit that turns the memory-access requests produced by the ARM instruction decoder into AHB-Lite master transfers. It returns load data, aligned to the destination and sign- or zero-extended, to register writeback. It sits between the decode/execute stage, which supplies the address, store data, size and signedness, and the system AHB-Lite bus. It issues one single-beat transfer at a time.

## Interface
Parameters: none (bus width fixed at 32 bits).

- clk  in  1  system clock; all state on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  access request; held stable until accepted
- req_ready  out  1  high in IDLE; a request is accepted when req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  sign-extend load result (byte and halfword loads only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_rd_id  in  5  destination register id, echoed on the response
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  qualifies rsp_valid: bus error, misaligned access or illegal size
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_rd_id  out  5  captured req_rd_id
- HADDR  out  32; HTRANS  out  2; HWRITE  out  1; HSIZE  out  3; HBURST  out  3 (always 000, SINGLE); HWDATA  out  32
- HRDATA  in  32; HREADY  in  1; HRESP  in  1

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: on acceptance, capture all req_* fields.
  - If the access is illegal (size 11, or misaligned and not rotatable; see Configuration), go to RESP with error.
  - Otherwise go to ADDR.
- ADDR: drive HTRANS=10 (NONSEQ), HADDR, HWRITE, HSIZE={0,size}. Hold these until HREADY=1, then go to DATA.
- DATA: drive HTRANS=00 (no pipelined next address) and HWDATA. When HREADY=1, capture HRDATA and HRESP, then go to RESP.
- RESP: assert rsp_valid for one cycle, then return to IDLE.
  - rsp_err is set if HRESP was 1 on the completing cycle, or if the access was rejected in IDLE.
- Write lane replication:
  - byte: HWDATA = {4{wdata[7:0]}}
  - halfword: HWDATA = {2{wdata[15:0]}}
  - word: HWDATA = wdata
- Read extraction:
  - byte: lane selected by addr[1:0].
  - halfword: lane selected by addr[1].
  - Result is sign-extended when req_signed=1, otherwise zero-extended. req_signed is ignored for words and stores.
- Misaligned access: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - A misaligned halfword is always rejected.
  - Rejected accesses never touch the bus.
- Two-cycle AHB ERROR response: the first cycle (HREADY=0, HRESP=1) is waited through. HTRANS is already IDLE, so no cancellation is needed.

## Timing
- Reset values (async, immediate):
  - state IDLE, so req_ready=1.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0, rsp_rd_id=0.
  - HTRANS=00, HADDR=0, HWRITE=0, HSIZE=000, HWDATA=0.
- All bus and rsp outputs are registered.
- Zero-wait access: accept at T0, address phase T1, data phase T2, rsp_valid at T3, req_ready high again at T4. Throughput is one access per 4 cycles.
- Each HREADY=0 cycle adds one cycle to the current phase.
- Rejected access: accept at T0, rsp_valid with rsp_err=1 at T1.
- Reset mid-transfer: the FSM returns to IDLE and HTRANS goes to 00 immediately. No response is produced for the aborted access.
- req_* are don't-care outside the acceptance cycle.

## Configuration
- LSU_UNALIGNED_ROTATE_EN defined (ARMv4 behaviour):
  - A misaligned word access is issued with HADDR[1:0]=00.
  - Load data is rotated right by 8×addr[1:0].
  - Store data is written unrotated.
  - No error is raised.
- LSU_UNALIGNED_ROTATE_EN undefined: a misaligned word access is rejected with rsp_err=1 and no bus activity.

## Test plan
- Word store to 0x0000_1000 with wdata 0xDEAD_BEEF, zero wait → HTRANS=10 / HWRITE=1 / HSIZE=010 at T1; HWDATA=0xDEADBEEF at T2; rsp_valid, rsp_err=0 at T3.
- Signed byte load at 0x...03, HRDATA=0x80AA_BBCC → rsp_rdata=0xFFFF_FF80. Unsigned halfword load at 0x...02 with the same HRDATA → rsp_rdata=0x0000_80AA.
- Word load with 2 HREADY=0 cycles in the address phase and 3 in the data phase → rsp_valid at T8, HADDR stable throughout the address phase.
- ERROR response (HREADY=0/HRESP=1, then HREADY=1/HRESP=1) → rsp_err=1, rsp_rdata=0, req_ready returns to 1.
- Word load at 0x...01, HRDATA=0x4433_2211:
  - with the macro → HADDR=0x...00, rsp_rdata=0x1144_3322.
  - without the macro → no HTRANS activity, rsp_err=1 at T1.
- Reset asserted during DATA → HTRANS=00 and rsp_valid=0 immediately; a new request is accepted at the first edge after release.
